// File: rtl/sensor_filter_pkg.sv
// Shared types and default thresholds for the sensor conditioning stage.
package sensor_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TORQ,
        CURR,
        STAT
    } state_e;

    localparam logic [11:0] BATT_LOW_THR_DEF = 12'hA98;
    localparam logic [11:0] BATT_HYST_DEF    = 12'h040;
    localparam logic [11:0] BRAKE_THR_DEF    = 12'h800;

    typedef struct packed {
        logic [11:0] batt;
        logic [11:0] curr;
        logic [11:0] brake;
        logic [11:0] torque;
    } snap_t;

endpackage

// File: rtl/sensor_filter_ema_update.sv
// Combinational EMA step: acc - acc/2^SHIFT + x, or a direct seed of x.
module ema_update #(
    parameter int SHIFT = 4
) (
    input  logic [11+SHIFT:0] acc,
    input  logic [11:0]       x,
    input  logic              seed,
    output logic [11+SHIFT:0] acc_nxt
);

    localparam int AW = 12 + SHIFT;

    logic [AW-1:0] x_ext;
    logic [AW-1:0] leak;

    assign x_ext = {{SHIFT{1'b0}}, x};
    assign leak  = acc >> SHIFT;

    // Bounded by 4095*2^SHIFT, so no headroom bit is needed.
    assign acc_nxt = seed ? {x, {SHIFT{1'b0}}}
                          : acc - leak + x_ext;

endmodule

// File: rtl/sensor_filter.sv
// Periodic snapshot, torque/current EMAs and battery/brake flags.
// Define SENSOR_FILTER_BATT_HYST_EN for battery-low hysteresis.
module sensor_filter
    import sensor_filter_pkg::*;
#(
    parameter int          SAMPLE_PERIOD = 4096,
    parameter int          SHIFT         = 4,
    parameter logic [11:0] BATT_LOW_THR  = BATT_LOW_THR_DEF,
    parameter logic [11:0] BATT_HYST     = BATT_HYST_DEF,
    parameter logic [11:0] BRAKE_THR     = BRAKE_THR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] brake,
    input  logic [11:0] torque,
    output logic [11:0] avg_torque,
    output logic [11:0] avg_curr,
    output logic        batt_low,
    output logic        brake_active,
    output logic        valid,
    output logic        upd
);

    localparam int TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 2;
    localparam int AW = 12 + SHIFT;
    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    snap_t         snap_q, snap_d;
    logic [AW-1:0] acc_t_q, acc_t_d;
    logic [AW-1:0] acc_c_q, acc_c_d;
    logic          batt_low_q, batt_low_d;
    logic          brake_active_q, brake_active_d;
    logic          valid_q, valid_d;
    logic          upd_q, upd_d;

    logic          tc;
    logic          sel_curr;
    logic [AW-1:0] ema_acc;
    logic [11:0]   ema_x;
    logic [AW-1:0] ema_nxt;
    logic          batt_below;
    logic          batt_low_new;

    assign tc       = (tmr_q == TMR_LAST);
    assign sel_curr = (state_q == CURR);
    assign ema_acc  = sel_curr ? acc_c_q : acc_t_q;
    assign ema_x    = sel_curr ? snap_q.curr : snap_q.torque;

    ema_update #(
        .SHIFT   (SHIFT)
    ) u_ema (
        .acc     (ema_acc),
        .x       (ema_x),
        .seed    (!valid_q),
        .acc_nxt (ema_nxt)
    );

    assign batt_below = (snap_q.batt < BATT_LOW_THR);

`ifdef SENSOR_FILTER_BATT_HYST_EN
    localparam logic [12:0] BATT_CLR_THR =
        {1'b0, BATT_LOW_THR} + {1'b0, BATT_HYST};

    logic batt_above;

    assign batt_above = ({1'b0, snap_q.batt} >= BATT_CLR_THR);

    always_comb begin
        batt_low_new = batt_low_q;
        unique case (1'b1)
            batt_below: batt_low_new = 1'b1;
            batt_above: batt_low_new = 1'b0;
            default:    batt_low_new = batt_low_q;
        endcase
    end
`else
    assign batt_low_new = batt_below;
`endif

    always_comb begin
        state_d        = state_q;
        tmr_d          = tc ? '0 : tmr_q + 1'b1;
        snap_d         = snap_q;
        acc_t_d        = acc_t_q;
        acc_c_d        = acc_c_q;
        batt_low_d     = batt_low_q;
        brake_active_d = brake_active_q;
        valid_d        = valid_q;
        upd_d          = 1'b0;

        // All four channels latched together so a pass sees one instant.
        if (tc) begin
            snap_d = '{batt: batt, curr: curr,
                       brake: brake, torque: torque};
        end

        unique case (state_q)
            IDLE: begin
                if (tc) state_d = TORQ;
            end
            TORQ: begin
                acc_t_d = ema_nxt;
                state_d = CURR;
            end
            CURR: begin
                acc_c_d = ema_nxt;
                state_d = STAT;
            end
            STAT: begin
                brake_active_d = (snap_q.brake < BRAKE_THR);
                batt_low_d     = batt_low_new;
                valid_d        = 1'b1;
                upd_d          = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            snap_q         <= '0;
            acc_t_q        <= '0;
            acc_c_q        <= '0;
            batt_low_q     <= 1'b0;
            brake_active_q <= 1'b0;
            valid_q        <= 1'b0;
            upd_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            snap_q         <= snap_d;
            acc_t_q        <= acc_t_d;
            acc_c_q        <= acc_c_d;
            batt_low_q     <= batt_low_d;
            brake_active_q <= brake_active_d;
            valid_q        <= valid_d;
            upd_q          <= upd_d;
        end
    end

    assign avg_torque   = acc_t_q[11+SHIFT:SHIFT];
    assign avg_curr     = acc_c_q[11+SHIFT:SHIFT];
    assign batt_low     = batt_low_q;
    assign brake_active = brake_active_q;
    assign valid        = valid_q;
    assign upd          = upd_q;

endmodule

// File: doc/sensor_filter.md
# sensor_filter

Conditioning stage downstream of the A2D interface. It snapshots the four 12-bit channel registers (`batt`, `curr`, `brake`, `torque`) on a fixed sample period. It maintains exponential moving averages of torque and current, and derives registered `batt_low` and `brake_active` flags. The averages and flags feed the eBike control and telemetry logic.

## Interface
- `SAMPLE_PERIOD`, 4096: clocks between snapshots; legal range ≥ 4.
- `SHIFT`, 4: EMA weight is 1/2^SHIFT; legal range 1..8.
- `BATT_LOW_THR`, 12'hA98: battery-low set threshold.
- `BATT_HYST`, 12'h040: clear threshold is `BATT_LOW_THR + BATT_HYST` (only used with the hysteresis macro).
- `BRAKE_THR`, 12'h800: brake is active when the reading is below this value.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `batt` in 12: battery reading from the A2D interface.
- `curr` in 12: current reading from the A2D interface.
- `brake` in 12: brake-lever reading from the A2D interface.
- `torque` in 12: torque reading from the A2D interface.
- `avg_torque` out 12: torque EMA.
- `avg_curr` out 12: current EMA.
- `batt_low` out 1: battery-low flag.
- `brake_active` out 1: brake flag.
- `valid` out 1: high once the first sample has been processed.
- `upd` out 1: one-cycle pulse when a processing pass completes.

## Operation
- **Sample timer:** `tmr` is free-running over 0..SAMPLE_PERIOD-1 and wraps to 0. `tc = (tmr == SAMPLE_PERIOD-1)`.
- **Snapshot:** on `tc`, all four inputs are captured into snapshot registers. This keeps the channels coherent within a pass.
- **FSM states:** IDLE → TORQ → CURR → STAT → IDLE.
  - IDLE → TORQ on `tc`.
  - All other transitions are unconditional, one per clock.
  - `tc` can never occur outside IDLE, because SAMPLE_PERIOD ≥ 4.
- **Accumulators:** `acc_t` and `acc_c` are unsigned, 12+SHIFT bits each. One shared update unit is used: TORQ updates `acc_t`, CURR updates `acc_c`.
  - **Seed (`valid`=0):** `acc = x << SHIFT`.
  - **Normal:** `acc = acc - (acc >> SHIFT) + x`. This provably never exceeds 4095·2^SHIFT, so no saturation logic is needed and overflow is impossible.
- **Average outputs:** `avg_* = acc[11+SHIFT:SHIFT]`. A constant input x converges exactly to x.
- **STAT state:**
  - `brake_active` ← `brake_snap < BRAKE_THR`.
  - `batt_low` is updated per the Configuration section.
  - `valid` ← 1.
  - `upd` is asserted.
- **Reset:** everything clears immediately, including mid-pass. After reset release, the next pass re-seeds.

## Timing
- **Reset values:** every output is 0, `tmr` = 0, FSM is in IDLE, and both accumulators are 0.
- **First snapshot:** `tc` is first high in the cycle SAMPLE_PERIOD-1 after reset release. The snapshot is taken at that cycle's edge.
- **Output update edges** (edge 0 = the `tc` edge):
  - `avg_torque` changes at edge 1 (leaving TORQ).
  - `avg_curr` changes at edge 2 (leaving CURR).
  - `batt_low`, `brake_active` and `valid` change at edge 3 (leaving STAT).
  - `upd` is high for exactly the one cycle following edge 3.
- **Stable window:** outputs are stable for SAMPLE_PERIOD-3 cycles per period.
- **Input sensitivity:** input changes between `tc` edges have no effect.

## Configuration
- `SENSOR_FILTER_BATT_HYST_EN` defined:
  - `batt_low` sets when `batt_snap < BATT_LOW_THR`.
  - It clears when `batt_snap ≥ BATT_LOW_THR + BATT_HYST`.
  - Otherwise it holds its value.
- `SENSOR_FILTER_BATT_HYST_EN` not defined:
  - `batt_low = (batt_snap < BATT_LOW_THR)` each pass, with no hysteresis.
  - `BATT_HYST` is unused.

## Structure
- **Package `sensor_filter_pkg`:** the FSM state enum (IDLE, TORQ, CURR, STAT) and the default threshold constants.
- **Sub-module `ema_update`:** combinational, parameterised by SHIFT.
  - Inputs: `acc`, `x`, `seed`.
  - Output: next `acc`.
  - A single instance is muxed between the torque and current channels.

## Test plan
All tests use SAMPLE_PERIOD=16 and SHIFT=4.
- **Steady input:** torque=12'h400, curr=12'h123 held constant → at the first `upd`, `avg_torque`=12'h400, `avg_curr`=12'h123, `valid`=1. `upd` occurs in cycle 19 after reset release, and every 16 cycles thereafter.
- **Step response:** seed torque=12'h000, then step to 12'hFFF → the next pass gives `avg_torque`=12'h0FF. It rises monotonically and reaches exactly 12'hFFF, never wrapping.
- **Battery hysteresis:** batt sequence 12'hA00, then 12'hAA0, then 12'hAE0.
  - With `SENSOR_FILTER_BATT_HYST_EN`: `batt_low` = 1, 1, 0.
  - Without the macro: `batt_low` = 1, 0, 0.
- **Brake threshold:** brake=12'h100 gives `brake_active`=1; 12'h7FF gives 1; 12'h800 gives 0; 12'hF00 gives 0.
- **Coherent snapshot:** change torque to 12'h000 in the cycle right after `tc` → `avg_torque` for that pass is unchanged. The new value is used only at the next `tc`.
- **Reset mid-pass:** assert `rst_n`=0 while in CURR → all outputs read 0 in the same cycle. After release with torque=12'h555, the first pass seeds `avg_torque`=12'h555 directly, with no ramp.
